// File: rtl/sqrt_share_pkg.sv
// rtl/sqrt_share_pkg.sv - shared state encodings and default widths for the sqrt sharing arbiter
package sqrt_share_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Match the shared sqrt core's a_bi / y_bo widths.
    localparam int A_W_DEF = 10;
    localparam int Y_W_DEF = 5;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotating-priority picker, searching upward from ptr_i+1 with wrap
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = '0;
        for (int off = 1; off <= N; off++) begin
            k = IW'((int'(ptr_i) + off) % N);
            if (!any_o && req_i[k]) begin
                any_o    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = k;
            end
        end
    end

endmodule

// File: rtl/sqrt_share_arb.sv
// rtl/sqrt_share_arb.sv - round-robin time-sharing of one iterative sqrt core among N_REQ requesters
module sqrt_share_arb
    import sqrt_share_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int A_W     = A_W_DEF,
    parameter int Y_W     = Y_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [N_REQ-1:0]   req_i,
    input  logic [N_REQ*A_W-1:0] a_bi,
    output logic [N_REQ-1:0]   gnt_o,
    output logic [N_REQ-1:0]   done_o,
    output logic [Y_W-1:0]     y_bo,
    output logic               err_o,
    output logic               busy_o,
    output logic [A_W-1:0]     core_a_o,
    output logic               core_start_o,
    input  logic               core_busy_i,
    input  logic [Y_W-1:0]     core_y_i
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [1:0]       state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [N_REQ-1:0] done_q, done_d;
    logic [Y_W-1:0]   y_q, y_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             start_q, start_d;
    logic [A_W-1:0]   core_a_q, core_a_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    ptr_q, ptr_d;
    logic [IW-1:0]    own_q, own_d;

    logic [N_REQ-1:0] pick_gnt;
    logic [IW-1:0]    pick_idx;
    logic             pick_any;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        y_d      = y_q;
        err_d    = 1'b0;
        start_d  = 1'b0;
        core_a_d = core_a_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        own_d    = own_q;
        case (state_q)
            S_IDLE: begin
                if (pick_any) begin
                    gnt_d    = pick_gnt;
                    own_d    = pick_idx;
                    core_a_d = a_bi[int'(pick_idx)*A_W +: A_W];
                    start_d  = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                // The core asserts busy one cycle after it sees start, so skip the first WAIT cycle.
                if (cnt_q != '0 && !core_busy_i) begin
                    y_d     = core_y_i;
                    done_d  = gnt_q;
                    state_d = S_DONE;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                gnt_d   = '0;
                ptr_d   = own_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            done_q   <= '0;
            y_q      <= '0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            start_q  <= 1'b0;
            core_a_q <= '0;
            cnt_q    <= '0;
            ptr_q    <= IW'(N_REQ - 1);
            own_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            y_q      <= y_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            start_q  <= start_d;
            core_a_q <= core_a_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            own_q    <= own_d;
        end
    end

    assign gnt_o        = gnt_q;
    assign done_o       = done_q;
    assign y_bo         = y_q;
    assign err_o        = err_q;
    assign busy_o       = busy_q;
    assign core_a_o     = core_a_q;
    assign core_start_o = start_q;

endmodule

// File: tb/tb_sqrt_share_arb.sv
// tb/tb_sqrt_share_arb.sv - self-checking bench for sqrt_share_arb with a stub iterative sqrt core
module tb_sqrt_share_arb;

    localparam int N  = 4;
    localparam int AW = 10;
    localparam int YW = 5;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  req;
    logic [N*AW-1:0] a_bi;
    logic [N-1:0]  gnt, done;
    logic [YW-1:0] y;
    logic          err, busy;
    logic [AW-1:0] core_a;
    logic          core_start;
    logic          core_busy;
    logic [YW-1:0] core_y;

    always #5 clk = ~clk;

    sqrt_share_arb #(.N_REQ(N), .A_W(AW), .Y_W(YW), .TIMEOUT(TO)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .a_bi         (a_bi),
        .gnt_o        (gnt),
        .done_o       (done),
        .y_bo         (y),
        .err_o        (err),
        .busy_o       (busy),
        .core_a_o     (core_a),
        .core_start_o (core_start),
        .core_busy_i  (core_busy),
        .core_y_i     (core_y)
    );

    typedef struct packed {
        logic [3:0]        req;
        logic [3:0][9:0]   a;
        logic [3:0][4:0]   y;
        int                ntx;
        int                lat;
    } vec_t;

    typedef struct packed {
        int         idx;
        logic [4:0] y;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   model_ptr = N - 1;
    bit   hold_mode = 1'b0;
    int   start_cnt = 0;
    int   lat = 2;
    bit   hang = 1'b0;
    int   core_cnt;

    function automatic int isqrt(input int v);
        int r = 0;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    // Stub core: busy for lat cycles after start (or forever while hang), result from its latched operand.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_busy <= 1'b0;
            core_cnt  <= 0;
            core_y    <= '0;
        end else if (core_start) begin
            core_busy <= 1'b1;
            core_cnt  <= lat;
            core_y    <= YW'(isqrt(int'(core_a)));
        end else if (core_busy && !hang) begin
            if (core_cnt <= 1) core_busy <= 1'b0;
            core_cnt <= core_cnt - 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (core_start) start_cnt++;
            if (err) req = req & ~gnt;
            if (done != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("done_onehot", 32'(done), 32'(1) << e.idx);
                    check("y_bo", 32'(y), 32'(e.y));
                    check("gnt_matches_done", 32'(gnt), 32'(done));
                    if (!hold_mode) req = req & ~done;
                    if (sb.size() == 0) req = '0;
                end
            end
        end
    end

    function automatic vec_t mk(input logic [3:0] r, input int a0, a1, a2, a3,
                                input int y0, y1, y2, y3, input int ntx, input int l);
        vec_t v;
        v.req = r;
        v.a[0] = 10'(a0); v.a[1] = 10'(a1); v.a[2] = 10'(a2); v.a[3] = 10'(a3);
        v.y[0] = 5'(y0);  v.y[1] = 5'(y1);  v.y[2] = 5'(y2);  v.y[3] = 5'(y3);
        v.ntx = ntx;
        v.lat = l;
        return v;
    endfunction

    task automatic push_vec(input vec_t v, output int n);
        logic [3:0] pend;
        int k, kk;
        exp_t e;
        pend = v.req;
        n = (v.ntx > 0) ? v.ntx : $countones(v.req);
        for (int t = 0; t < n; t++) begin
            k = model_ptr;
            for (int off = 1; off <= N; off++) begin
                kk = (model_ptr + off) % N;
                if (pend[kk]) begin
                    k = kk;
                    break;
                end
            end
            e.idx = k;
            e.y   = v.y[k];
            sb.push_back(e);
            model_ptr = k;
            if (v.ntx == 0) pend[k] = 1'b0;
        end
    endtask

    task automatic wait_sb(input int bound);
        int c = 0;
        while (sb.size() != 0 && c < bound) begin
            @(negedge clk); #1;
            c++;
        end
        if (sb.size() != 0) begin
            check("sb_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
            req = '0;
        end
    endtask

    task automatic wait_gnt(input string name, input logic [3:0] exp);
        int c = 0;
        while (gnt == '0 && c < 100) begin
            @(negedge clk); #1;
            c++;
        end
        check(name, 32'(gnt), 32'(exp));
    endtask

    task automatic run_vec(input vec_t v);
        int n, s0;
        lat       = v.lat;
        hold_mode = (v.ntx > 0);
        a_bi      = v.a;
        s0        = start_cnt;
        push_vec(v, n);
        @(negedge clk);
        req = v.req;
        wait_sb(4000);
        @(negedge clk); #1;
        check("busy_after_done", 32'(busy), 32'd0);
        check("gnt_after_done", 32'(gnt), 32'd0);
        check("start_pulses", 32'(start_cnt - s0), 32'(n));
    endtask

    vec_t vt[7];
    int   n_cyc;

    initial begin
        vt[0] = mk(4'b1111, 1023, 144, 0, 15, 31, 12, 0, 3, 0, 3);
        vt[1] = mk(4'b0101, 400, 0, 81, 0, 20, 0, 9, 0, 6, 3);
        vt[2] = mk(4'b0001, 100, 0, 0, 0, 10, 0, 0, 0, 0, 2);
        vt[3] = mk(4'b1010, 0, 625, 0, 999, 0, 25, 0, 31, 0, 5);
        vt[4] = mk(4'b0110, 0, 3, 960, 0, 0, 1, 30, 0, 0, 1);
        vt[5] = mk(4'b0101, 49, 0, 256, 0, 7, 0, 16, 0, 0, 4);
        vt[6] = mk(4'b0001, 225, 0, 0, 0, 15, 0, 0, 0, 0, 7);

        rst_n = 1'b0;
        req   = '0;
        a_bi  = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(core_start), 32'd0);
        check("rst_core_a", 32'(core_a), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_vec(vt[0]);
        run_vec(vt[1]);
        run_vec(vt[2]);

        // Requester 1 drops its request and changes its operand after the grant.
        begin
            exp_t e;
            lat = 6;
            hold_mode = 1'b0;
            a_bi = '0;
            a_bi[AW*1 +: AW] = 10'd529;
            e.idx = 1; e.y = 5'd23;
            sb.push_back(e);
            model_ptr = 1;
            @(negedge clk);
            req = 4'b0010;
            wait_gnt("drop_gnt", 4'b0010);
            @(negedge clk);
            a_bi[AW*1 +: AW] = 10'd1023;
            req = '0;
            wait_sb(200);
            check("drop_core_a", 32'(core_a), 32'd529);
        end

        // Hung core: watchdog abort, no done, then normal service.
        hang = 1'b1;
        a_bi = '0;
        a_bi[AW*0 +: AW] = 10'd50;
        @(negedge clk);
        req = 4'b0001;
        wait_gnt("hang_gnt", 4'b0001);
        n_cyc = 0;
        while (!err && n_cyc < 200) begin
            @(negedge clk); #1;
            n_cyc++;
        end
        check("err_latency", 32'(n_cyc), 32'(TO + 2));
        check("err_no_done", 32'(done), 32'd0);
        @(negedge clk); #1;
        check("err_one_cycle", 32'(err), 32'd0);
        hang = 1'b0;
        model_ptr = 0;
        repeat (10) @(negedge clk);
        run_vec(vt[6]);
        run_vec(vt[3]);
        run_vec(vt[4]);

        // Reset in the middle of WAIT.
        lat = 20;
        a_bi = '0;
        a_bi[AW*2 +: AW] = 10'd100;
        @(negedge clk);
        req = 4'b0100;
        wait_gnt("rstwait_gnt", 4'b0100);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rstwait_gnt0", 32'(gnt), 32'd0);
        check("rstwait_done0", 32'(done), 32'd0);
        check("rstwait_busy0", 32'(busy), 32'd0);
        check("rstwait_y0", 32'(y), 32'd0);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        model_ptr = N - 1;
        repeat (30) @(negedge clk);
        #1;
        check("rstwait_idle", 32'(busy), 32'd0);
        run_vec(vt[5]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/sqrt_share_arb.md
Name: sqrt_share_arb

Overview:
- Round-robin scheduler that time-shares one iterative square-root core among N_REQ requesters.
- Presents each requester a level request / one-hot grant / done-pulse interface.
- Drives the core's start/busy handshake, returns the result and recovers from a hung core via a watchdog.
- Sits between the function-level controllers (the a+cbrt(b) pipelines) and the single shared sqrt instance.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- A_W, 10, operand width (core a_bi width).
- Y_W, 5, result width (core y_bo width).
- TIMEOUT, 64, max WAIT cycles before abort (must be ≥ the core's worst-case latency + 2).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  N_REQ  level request per requester; held with its operand until done_o or err_o.
- a_bi  in  N_REQ*A_W  packed operands; requester k at bits [k*A_W +: A_W].
- gnt_o  out  N_REQ  one-hot owner of the core; zero when idle.
- done_o  out  N_REQ  one-cycle one-hot pulse: result for that requester is valid on y_bo.
- y_bo  out  Y_W  last captured result; holds until the next capture.
- err_o  out  1  one-cycle pulse on watchdog abort.
- busy_o  out  1  high in any state other than IDLE.
- core_a_o  out  A_W  operand to the core.
- core_start_o  out  1  start pulse to the core.
- core_busy_i  in  1  core busy.
- core_y_i  in  Y_W  core result.

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE; all outputs 0; rr_ptr=N_REQ-1, so requester 0 wins first; wait_cnt=0.
  - Reset mid-operation abandons the transaction and emits no done_o.
  - The core is reset by the same system reset (integrator inverts it for the core's active-high input).
- All outputs are registered; states are IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If req_i≠0, pick the winner by searching from rr_ptr+1 upward with wrap.
  - Latch the winner's operand into core_a_o, set gnt_o one-hot and go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - core_start_o=1 for exactly this one cycle; wait_cnt←0; go to WAIT.
- WAIT:
  - core_start_o=0 and wait_cnt increments every cycle.
  - core_busy_i is ignored while wait_cnt=0, because the core raises busy one cycle after start.
  - If wait_cnt≥1 and core_busy_i=0: y_bo←core_y_i, done_o←gnt_o, go to DONE.
  - Else if wait_cnt=TIMEOUT: err_o=1 and go to DONE with no done_o.
- DONE:
  - done_o and err_o return to 0; gnt_o←0.
  - rr_ptr←index of the just-served requester; go to IDLE. req_i is ignored in this cycle.
- Latency: req_i sampled at edge 0 gives gnt_o at edge 1 and core_start_o high in cycle 1–2. If the core stays busy for K cycles, done_o pulses at edge 3+K.
- Fairness: a continuously requesting set is served in strict rotation; no requester waits more than N_REQ-1 transactions.
- Requester drops req_i mid-transaction: the transaction still completes and done_o still pulses (the requester may ignore it). The grant is not revoked.
- Operand changes after the grant edge have no effect (latched).
- Simultaneous requests in IDLE resolve by rr_ptr only; there is no fixed priority.
- The same requester re-requesting immediately goes through one IDLE cycle and is served again only if no other req_i is high.
- core_busy_i high in IDLE/ISSUE is ignored.
- Widths: no arithmetic beyond the wait_cnt counter, sized clog2(TIMEOUT+1).

Decomposition:
- Shared header (sqrt_share_pkg include) holds:
  - state encodings IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3;
  - default widths A_W/Y_W, matching the sqrt core.
- One sub-module, rr_pick: combinational rotating-priority picker.
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant, index and any.
  - Reusable by a later cbrt-sharing arbiter.

Test Plan:
- Single request: req_i=0001, a_bi[9:0]=100, real sqrt core → gnt_o=0001; one core_start_o pulse; done_o=0001 with y_bo=10; busy_o low the cycle after DONE.
- All four request at once with operands 1023, 144, 0, 15 → served in order 0,1,2,3 with y_bo=31, 12, 0, 3; each done_o one-hot and matching the gnt_o of that transaction.
- Fairness: req_i held at 0101 for 6 transactions → grant sequence 0,2,0,2,0,2; requester 0 never served twice in a row.
- Hung core: stub holds core_busy_i=1 forever → err_o pulses exactly TIMEOUT+2 cycles after gnt_o; no done_o; the next request is served normally.
- Reset mid-WAIT: rst_ni low for 1 cycle during WAIT → gnt_o, done_o, busy_o, y_bo go to 0 immediately (async); no done_o afterwards; first post-reset grant goes to requester 0.
- Requester drops req_i during WAIT and the operand changes after grant → done_o still pulses for it, and y_bo equals sqrt of the operand latched at grant.
